// File: rtl/btn_debounce.sv
// btn_debounce: per-channel two-flop synchronizer, consecutive-sample debouncer
// and optional press strobe. Ports: clk_10k, rst, raw_btn, d_btn, btn_press.
// Macro BTN_PRESS_PULSE_EN: when undefined btn_press is tied to zero.
module btn_debounce #(
  parameter int NBTN   = 8,
  parameter int DB_CNT = 200
) (
  input  logic            clk_10k,
  input  logic            rst,
  input  logic [NBTN-1:0] raw_btn,
  output logic [NBTN-1:0] d_btn,
  output logic [NBTN-1:0] btn_press
);

  localparam logic [15:0] LAST = 16'(DB_CNT - 1);

  logic [NBTN-1:0]       sync1;
  logic [NBTN-1:0]       sync2;
  logic [NBTN-1:0][15:0] cnt_q;
  logic [NBTN-1:0][15:0] cnt_d;
  logic [NBTN-1:0]       lvl_d;

  always_ff @(posedge clk_10k or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_btn;
      sync2 <= sync1;
    end
  end

  // A matching sample wipes the run; the DB_CNT-th
  // consecutive mismatch flips the accepted level.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = d_btn;
    for (int i = 0; i < NBTN; i++) begin
      unique case (1'b1)
        (sync2[i] == d_btn[i]): begin
          cnt_d[i] = '0;
        end
        (sync2[i] != d_btn[i]) && (cnt_q[i] == LAST): begin
          cnt_d[i] = '0;
          lvl_d[i] = sync2[i];
        end
        (sync2[i] != d_btn[i]) && (cnt_q[i] != LAST): begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_10k or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      d_btn <= '0;
    end else begin
      cnt_q <= cnt_d;
      d_btn <= lvl_d;
    end
  end

`ifdef BTN_PRESS_PULSE_EN
  // Registered alongside d_btn so the strobe lines
  // up with the first cycle the new high level shows.
  always_ff @(posedge clk_10k or posedge rst) begin
    if (rst) begin
      btn_press <= '0;
    end else begin
      btn_press <= lvl_d & ~d_btn;
    end
  end
`else
  assign btn_press = '0;
`endif

endmodule
